// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider producing {remainder, quotient}.
// One step per cycle after operands are latched; supports flush abort and a divide-by-zero shortcut.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: execute holds start_i high until it sees ready_o; ready_o and
  // result_o stay stable while start_i remains high, and both clear on the
  // edge where start_i is seen low.

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_e;

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                sgn_q, sgn_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W+1:0]   trial;
  logic                fits;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // rem_sh needs one extra bit: a shifted remainder can reach 2*divisor-1.
  assign rem_sh  = {rem_q, dvd_q[DATA_W-1]};
  assign trial   = {1'b0, rem_sh} - {2'b00, dvs_q};
  assign fits    = ~trial[DATA_W+1];

  assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
  assign rem_fix = (sgn_q && neg1_q) ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d = ST_ON;
            dvd_d   = mag1;
            dvs_d   = mag2;
            rem_d   = '0;
            cnt_d   = '0;
            sgn_d   = signed_div_i;
            neg1_d  = opdata1_i[DATA_W-1];
            neg2_d  = opdata2_i[DATA_W-1];
          end
        end
      end
      ST_BYZERO: begin
        state_d  = ST_END;
        result_d = '0;
      end
      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          // dvd_q shifts dividend bits out the top and quotient bits in the bottom.
          rem_d = fits ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          dvd_d = {dvd_q[DATA_W-2:0], fits};
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_END;
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          ready_d  = 1'b1;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases from the handshake/abort/reset scenarios
// plus randomized operands checked against a plain-arithmetic division model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        ready_prev = 1'b0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: truncating division, remainder takes the dividend's sign
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // monitor: compares on each rising ready_o
  always @(negedge clk) begin
    if (rst && ready_o && !ready_prev) begin
      if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
      else check("result", result_o, exp_q.pop_front());
    end
    ready_prev <= ready_o;
  end

  // driver tasks: all called just after a negedge
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int   lat;
    logic seen;
    exp_q.push_back(exp);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat  = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    while (!seen && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = ready_o;
    end
    check("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold);
    launch(sg, a, b, exp);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'd0);
  endtask

  task automatic run_model(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    run_div(sg, a, b, model(sg, a, b), hold);
  endtask

  task automatic watch_no_ready(input string name, input int cycles);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_o) hits++;
    end
    check(name, 64'(hits), 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #3;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed cases with independently known answers
    run_div(1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1);
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
    run_div(1'b0, 32'h12345678, 32'd0, 64'd0, 2);
    run_div(1'b1, 32'h80000000, 32'd0, 64'd0, 0);
    run_div(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 5);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
    run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 0);
    run_div(1'b0, 32'd5, 32'hFFFFFFFF, 64'h00000005_00000000, 0);

    // annul at iteration 10: back to FREE, no result
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    watch_no_ready("annul_no_ready", 40);
    run_model(1'b1, 32'hFFFF0000, 32'd7, 0);

    // annul held in FREE blocks the start
    opdata1_i = 32'd99;
    opdata2_i = 32'd4;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    watch_no_ready("annul_free_no_ready", 6);
    annul_i = 1'b0;
    run_div(1'b0, 32'd99, 32'd4, 64'h00000003_00000018, 0);

    // async reset mid-division
    signed_div_i = 1'b0;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd17;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    start_i = 1'b0;
    #1;
    check("rst_on_ready", 64'(ready_o), 64'd0);
    check("rst_on_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_ready("rst_on_no_ready", 40);
    run_model(1'b0, 32'd12345, 32'd17, 0);

    // async reset while a result is being held
    launch(1'b1, 32'hFFFFFF00, 32'd9, model(1'b1, 32'hFFFFFF00, 32'd9));
    #2 rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(ready_o), 64'd0);
    check("rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // randomized operands
    for (int i = 0; i < 30; i++) begin
      logic        sg;
      logic [31:0] a, b;
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_model(sg, a, b, $urandom_range(0, 3));
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
